rvfi_trace_streamer: RTL and testbench

- Sits directly downstream of the single-cycle RISC-V datapath and consumes its registered RVFI retirement outputs, one record per clock.
- Captures each valid retirement into a record FIFO.
- Drains the FIFO as a 4-word, 32-bit-per-beat packet stream with a valid/ready handshake, feeding a trace sink (UART bridge, debug port, or testbench scoreboard).
- Overflow is counted, never back-pressured: the core has no stall input.

---
 rtl/rvfi_trace_streamer.sv | 246 ++++++++++++++++++++++++
 tb/tb_rvfi_trace_streamer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_trace_streamer.sv
// ---------------------------------------------------------------------------
// rvfi_trace_streamer
//
// Captures RISC-V RVFI retirement records from a single-cycle core into a
// small record FIFO and drains them as 4-beat, 32-bit packets over a
// valid/ready stream. The core cannot be stalled, so a record that arrives
// while the FIFO is full is dropped and counted instead of back-pressuring.
//
// Packet layout (one record = four beats, out_last on the fourth):
//   beat 0 : header   = {SYNC_BYTE, order[15:0], 2'b00, trap, rd_addr}
//   beat 1 : pc_rdata
//   beat 2 : insn
//   beat 3 : rd_wdata
//
// Ports:
//   clk            core clock, all state on the rising edge
//   rst            asynchronous, active-high reset
//   trace_en       capture enable (does not affect draining)
//   rvfi_*         registered retirement outputs of the datapath
//   out_valid      out_data holds a valid beat
//   out_ready      sink accepts the current beat
//   out_data       registered stream beat
//   out_last       marks the last beat of a packet
//   fifo_level     number of records currently stored
//   drop_count     records lost to overflow, saturating
//   halted         sticky, set when a halt record is captured
// ---------------------------------------------------------------------------
module rvfi_trace_streamer #(
    parameter int         DEPTH     = 8,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      trace_en,
    input  logic                      rvfi_valid,
    input  logic [63:0]               rvfi_order,
    input  logic [31:0]               rvfi_insn,
    input  logic                      rvfi_trap,
    input  logic                      rvfi_halt,
    input  logic [4:0]                rvfi_rd_addr,
    input  logic [31:0]               rvfi_rd_wdata,
    input  logic [31:0]               rvfi_pc_rdata,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_data,
    output logic                      out_last,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic [15:0]               drop_count,
    output logic                      halted
);

    localparam int AW = $clog2(DEPTH);   // slot index width
    localparam int PW = AW + 1;          // pointer width incl. wrap bit

    typedef struct packed {
        logic [31:0] hdr;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] wdata;
    } record_t;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PC,
        INSN,
        WDATA
    } state_t;

    // -----------------------------------------------------------------------
    // Record FIFO
    // -----------------------------------------------------------------------
    record_t          mem [DEPTH];
    record_t          new_rec;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic [AW-1:0]    rd_idx_next;
    logic             full;
    logic             empty;
    logic             push;
    logic             push_ok;
    logic             drop;
    logic             pop;
    logic             more_after_pop;

    // Only the low 16 bits of the order number travel in the header.
    logic             unused_order_hi;
    assign unused_order_hi = ^rvfi_order[63:16];

    assign wr_idx      = wr_ptr[AW-1:0];
    assign rd_idx      = rd_ptr[AW-1:0];
    assign rd_idx_next = rd_idx + AW'(1);

    // Wrap-bit pointers: equal means empty; same slot with opposite wrap
    // bits means every slot holds an unread record.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign fifo_level = wr_ptr - rd_ptr;

    // Fullness is judged on the state at the start of the cycle, so a push
    // into a full FIFO is lost even when the serializer pops on that edge.
    assign push    = rvfi_valid & trace_en & ~halted;
    assign push_ok = push & ~full;
    assign drop    = push & full;

    // The serializer can only preload a header that is already stored, so a
    // record written on the popping edge is picked up from IDLE instead.
    assign more_after_pop = (fifo_level > PW'(1));

    assign new_rec.hdr   = {SYNC_BYTE, rvfi_order[15:0], 2'b00, rvfi_trap, rvfi_rd_addr};
    assign new_rec.pc    = rvfi_pc_rdata;
    assign new_rec.insn  = rvfi_insn;
    assign new_rec.wdata = rvfi_rd_wdata;

    // NOTE: record storage has no reset; the pointers alone decide which
    // slots are meaningful, and leaving the array unreset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_idx] <= new_rec;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Overflow counter and sticky halt
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count <= '0;
            halted     <= 1'b0;
        end else begin
            if (drop && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
            // After the halt record nothing more is traced; later records are
            // simply not pushed, so they never count as drops.
            if (push && rvfi_halt) begin
                halted <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Packet serializer
    // -----------------------------------------------------------------------
    state_t        state;
    state_t        state_d;
    logic [31:0]   out_data_d;

    // out_valid is decoded from the state register, so the async reset of
    // the state drops it immediately and abandons any packet in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d    = state;
        out_data_d = out_data;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        pop        = 1'b0;

        unique case (state)
            IDLE: begin
                if (!empty) begin
                    state_d    = HDR;
                    out_data_d = mem[rd_idx].hdr;
                end
            end
            HDR: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d    = PC;
                    out_data_d = mem[rd_idx].pc;
                end
            end
            PC: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d    = INSN;
                    out_data_d = mem[rd_idx].insn;
                end
            end
            INSN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d    = WDATA;
                    out_data_d = mem[rd_idx].wdata;
                end
            end
            WDATA: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                if (out_ready) begin
                    pop = 1'b1;
                    // Preload the next header so packets run back to back.
                    if (more_after_pop) begin
                        state_d    = HDR;
                        out_data_d = mem[rd_idx_next].hdr;
                    end else begin
                        state_d    = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Beat register: only changes on a load or an accepted beat, which keeps
    // out_data stable while the sink stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
        end else begin
            out_data <= out_data_d;
        end
    end

endmodule

// File: tb/tb_rvfi_trace_streamer.sv
// ---------------------------------------------------------------------------
// Directed testbench for rvfi_trace_streamer (DEPTH=8, SYNC_BYTE=8'hA5).
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_rvfi_trace_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        trace_en;
    logic        rvfi_valid;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_insn;
    logic        rvfi_trap;
    logic        rvfi_halt;
    logic [4:0]  rvfi_rd_addr;
    logic [31:0] rvfi_rd_wdata;
    logic [31:0] rvfi_pc_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic [3:0]  fifo_level;
    logic [15:0] drop_count;
    logic        halted;

    int errors = 0;
    int checks = 0;

    rvfi_trace_streamer #(.DEPTH(8), .SYNC_BYTE(8'hA5)) dut (
        .clk           (clk),
        .rst           (rst),
        .trace_en      (trace_en),
        .rvfi_valid    (rvfi_valid),
        .rvfi_order    (rvfi_order),
        .rvfi_insn     (rvfi_insn),
        .rvfi_trap     (rvfi_trap),
        .rvfi_halt     (rvfi_halt),
        .rvfi_rd_addr  (rvfi_rd_addr),
        .rvfi_rd_wdata (rvfi_rd_wdata),
        .rvfi_pc_rdata (rvfi_pc_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .fifo_level    (fifo_level),
        .drop_count    (drop_count),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_rec(input logic [15:0] order, input logic [31:0] pc,
                           input logic [31:0] insn, input logic [31:0] wdata,
                           input logic [4:0] rd, input logic trap, input logic halt);
        rvfi_valid    = 1'b1;
        rvfi_order    = {48'h0, order};
        rvfi_pc_rdata = pc;
        rvfi_insn     = insn;
        rvfi_rd_wdata = wdata;
        rvfi_rd_addr  = rd;
        rvfi_trap     = trap;
        rvfi_halt     = halt;
    endtask

    task automatic reset_dut();
        rst        = 1'b1;
        rvfi_valid = 1'b0;
        out_ready  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits (bounded) for a valid beat with out_ready high, checks it, and
    // lets it be accepted on the next rising edge.
    task automatic expect_beat(input string tag, input logic [31:0] exp_data, input logic exp_last);
        int n;
        n = 0;
        out_ready = 1'b1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, {31'h0, out_valid}, 32'h1);
        check({tag, "_data"}, out_data, exp_data);
        check({tag, "_last"}, {31'h0, out_last}, {31'h0, exp_last});
        @(negedge clk);
    endtask

    // Overflow / full-test record table: order i, pc 0x1000+4i, trap on i=3.
    function automatic logic [31:0] tbl_word(input int i, input int w);
        logic [31:0] r;
        case (w)
            0:       r = {8'hA5, 16'(i), 2'b00, (i == 3), 5'(i)};
            1:       r = 32'h0000_1000 + 32'(i * 4);
            2:       r = 32'hC0DE_0000 + 32'(i);
            default: r = 32'hD000_0000 + 32'(i);
        endcase
        return r;
    endfunction

    task automatic push_tbl(input int i);
        set_rec(16'(i), tbl_word(i, 1), tbl_word(i, 2), tbl_word(i, 3), 5'(i), (i == 3), 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] pat;
        logic [31:0] bp_exp [4];
        logic [31:0] held;
        logic        stalled;
        int          beat;
        int          n;

        rst        = 1'b1;
        trace_en   = 1'b0;
        out_ready  = 1'b0;
        set_rec(16'h0, 32'h0, 32'h0, 32'h0, 5'h0, 1'b0, 1'b0);
        rvfi_valid = 1'b0;

        // ---------------- Reset values ----------------
        #1;
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_last", {31'h0, out_last}, 32'h0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_level", {28'h0, fifo_level}, 32'h0);
        check("rst_drop", {16'h0, drop_count}, 32'h0);
        check("rst_halted", {31'h0, halted}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b0;
        trace_en = 1'b1;

        // ---------------- Single record, exact latency ----------------
        out_ready = 1'b1;
        set_rec(16'd5, 32'h0000_0100, 32'h0050_0093, 32'h0000_0005, 5'd1, 1'b0, 1'b0);
        @(negedge clk);                                   // capture edge passed
        rvfi_valid = 1'b0;
        check("single_cap_valid", {31'h0, out_valid}, 32'h0);
        check("single_cap_level", {28'h0, fifo_level}, 32'h1);
        @(negedge clk);                                   // load edge passed
        check("single_b0_valid", {31'h0, out_valid}, 32'h1);
        check("single_b0_data", out_data, 32'hA500_0501);
        check("single_b0_last", {31'h0, out_last}, 32'h0);
        @(negedge clk);
        check("single_b1_data", out_data, 32'h0000_0100);
        check("single_b1_last", {31'h0, out_last}, 32'h0);
        @(negedge clk);
        check("single_b2_data", out_data, 32'h0050_0093);
        check("single_b2_last", {31'h0, out_last}, 32'h0);
        @(negedge clk);
        check("single_b3_data", out_data, 32'h0000_0005);
        check("single_b3_last", {31'h0, out_last}, 32'h1);
        check("single_b3_level", {28'h0, fifo_level}, 32'h1);
        @(negedge clk);
        check("single_end_valid", {31'h0, out_valid}, 32'h0);
        check("single_end_level", {28'h0, fifo_level}, 32'h0);

        // ---------------- Back-pressure ----------------
        bp_exp[0] = 32'hA500_0501;
        bp_exp[1] = 32'h0000_0100;
        bp_exp[2] = 32'h0050_0093;
        bp_exp[3] = 32'h0000_0005;
        pat       = 16'b1111_1101_0110_1001;              // LSB first: 1,0,0,1,0,1,1,0,...
        out_ready = 1'b0;
        set_rec(16'd5, 32'h0000_0100, 32'h0050_0093, 32'h0000_0005, 5'd1, 1'b0, 1'b0);
        @(negedge clk);
        rvfi_valid = 1'b0;
        beat    = 0;
        stalled = 1'b0;
        held    = '0;
        for (int i = 0; i < 40 && beat < 4; i++) begin
            if (stalled) begin
                check("bp_stall_valid", {31'h0, out_valid}, 32'h1);
                check("bp_stall_data", out_data, held);
            end
            out_ready = pat[i % 16];
            if (out_valid && out_ready) begin
                check("bp_beat_data", out_data, bp_exp[beat]);
                check("bp_beat_last", {31'h0, out_last}, {31'h0, (beat == 3)});
                beat++;
                stalled = 1'b0;
            end else begin
                stalled = out_valid;
                held    = out_data;
            end
            @(negedge clk);
        end
        check("bp_beat_count", 32'(beat), 32'd4);
        check("bp_end_level", {28'h0, fifo_level}, 32'h0);
        check("bp_end_valid", {31'h0, out_valid}, 32'h0);

        // ---------------- Overflow ----------------
        reset_dut();
        for (int i = 0; i < 11; i++) begin
            push_tbl(i);
            @(negedge clk);
        end
        rvfi_valid = 1'b0;
        check("ovf_level", {28'h0, fifo_level}, 32'd8);
        check("ovf_drop", {16'h0, drop_count}, 32'd3);
        check("ovf_stall_hdr", out_data, 32'hA500_0000);
        out_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            for (int w = 0; w < 4; w++) begin
                check("ovf_nobubble", {31'h0, out_valid}, 32'h1);
                check("ovf_data", out_data, tbl_word(r, w));
                check("ovf_last", {31'h0, out_last}, {31'h0, (w == 3)});
                @(negedge clk);
            end
        end
        check("ovf_end_valid", {31'h0, out_valid}, 32'h0);
        check("ovf_end_level", {28'h0, fifo_level}, 32'h0);
        check("ovf_end_drop", {16'h0, drop_count}, 32'd3);

        // ---------------- Halt ----------------
        reset_dut();
        check("halt_drop_cleared", {16'h0, drop_count}, 32'h0);
        set_rec(16'd1, 32'h0000_0200, 32'h0010_0113, 32'h0000_0011, 5'd2, 1'b0, 1'b0);
        @(negedge clk);
        check("halt_before", {31'h0, halted}, 32'h0);
        set_rec(16'd2, 32'h0000_0204, 32'h0010_0073, 32'h0000_0022, 5'd0, 1'b0, 1'b1);
        @(negedge clk);
        check("halt_set", {31'h0, halted}, 32'h1);
        set_rec(16'd3, 32'h0000_0208, 32'h0000_0013, 32'h0000_0033, 5'd3, 1'b0, 1'b0);
        @(negedge clk);
        rvfi_valid = 1'b0;
        check("halt_level", {28'h0, fifo_level}, 32'd2);
        check("halt_drop", {16'h0, drop_count}, 32'd0);
        expect_beat("halt_p1_b0", 32'hA500_0102, 1'b0);
        expect_beat("halt_p1_b1", 32'h0000_0200, 1'b0);
        expect_beat("halt_p1_b2", 32'h0010_0113, 1'b0);
        expect_beat("halt_p1_b3", 32'h0000_0011, 1'b1);
        expect_beat("halt_p2_b0", 32'hA500_0200, 1'b0);
        expect_beat("halt_p2_b1", 32'h0000_0204, 1'b0);
        expect_beat("halt_p2_b2", 32'h0010_0073, 1'b0);
        expect_beat("halt_p2_b3", 32'h0000_0022, 1'b1);
        repeat (4) @(negedge clk);
        check("halt_no_p3", {31'h0, out_valid}, 32'h0);
        check("halt_end_level", {28'h0, fifo_level}, 32'h0);
        check("halt_sticky", {31'h0, halted}, 32'h1);

        // ---------------- Full with simultaneous pop ----------------
        reset_dut();
        check("full_halt_cleared", {31'h0, halted}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            push_tbl(i);
            @(negedge clk);
        end
        rvfi_valid = 1'b0;
        check("full_level", {28'h0, fifo_level}, 32'd8);
        out_ready = 1'b1;
        n = 0;
        while (!out_last && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("full_at_last", {31'h0, out_last}, 32'h1);
        push_tbl(8);                                      // pop and push share this edge
        @(negedge clk);
        rvfi_valid = 1'b0;
        out_ready  = 1'b0;
        check("full_pop_drop", {16'h0, drop_count}, 32'd1);
        check("full_pop_level", {28'h0, fifo_level}, 32'd7);
        check("full_next_hdr", out_data, 32'hA500_0101);

        // ---------------- Reset mid-packet ----------------
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("midrst_at_pc", out_data, 32'h0000_1004);
        rst = 1'b1;
        #1;
        check("midrst_valid", {31'h0, out_valid}, 32'h0);
        check("midrst_level", {28'h0, fifo_level}, 32'h0);
        check("midrst_drop", {16'h0, drop_count}, 32'h0);
        check("midrst_halted", {31'h0, halted}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        set_rec(16'h0042, 32'h0000_0300, 32'h0420_0513, 32'h0000_0042, 5'd10, 1'b0, 1'b0);
        @(negedge clk);
        rvfi_valid = 1'b0;
        check("restart_idle", {31'h0, out_valid}, 32'h0);
        @(negedge clk);
        check("restart_hdr_valid", {31'h0, out_valid}, 32'h1);
        check("restart_hdr_data", out_data, 32'hA500_420A);
        check("restart_hdr_last", {31'h0, out_last}, 32'h0);
        @(negedge clk);
        expect_beat("restart_b1", 32'h0000_0300, 1'b0);
        expect_beat("restart_b2", 32'h0420_0513, 1'b0);
        expect_beat("restart_b3", 32'h0000_0042, 1'b1);
        check("restart_end_level", {28'h0, fifo_level}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
